// File: rtl/borrow_select_sub_pipe.sv
// Two-stage borrow-select subtractor: Diff = A - B - Bin with borrow-out and valid/ready flow control.
// Optional signed-overflow output Ovf is built only when SUB_OVF_EN is defined.
module borrow_select_sub_pipe #(
  parameter int WIDTH = 8,
  parameter int SPLIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int HW = WIDTH - SPLIT;

  logic             s1_valid_r;
  logic             s2_valid_r;
  logic             s2_adv_s;
  logic             accept_s;
  logic [SPLIT:0]   low_s;
  logic [HW:0]      hi0_s;
  logic [HW:0]      hi1_s;
  logic [SPLIT-1:0] low_r;
  logic             bl_r;
  logic [HW-1:0]    hi0_r;
  logic [HW-1:0]    hi1_r;
  logic             bh0_r;
  logic             bh1_r;
  logic [HW-1:0]    hi_sel_s;
  logic             bout_sel_s;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
`ifdef SUB_OVF_EN
  logic             sa_r;
  logic             sb_r;
  logic             ovf_r;
`endif

  assign s2_adv_s  = s1_valid_r & (~s2_valid_r | out_ready);
  assign in_ready  = ~s1_valid_r | s2_adv_s;
  assign accept_s  = in_valid & in_ready;
  assign out_valid = s2_valid_r;
  assign Diff      = diff_r;
  assign Bout      = bout_r;
`ifdef SUB_OVF_EN
  assign Ovf       = ovf_r;
`endif

  // Stage-1 slice arithmetic; the extra MSB of each result is that slice's borrow.
  always_comb begin
    low_s = {1'b0, A[SPLIT-1:0]} - {1'b0, B[SPLIT-1:0]} - {{SPLIT{1'b0}}, Bin};
    hi0_s = {1'b0, A[WIDTH-1:SPLIT]} - {1'b0, B[WIDTH-1:SPLIT]};
    hi1_s = hi0_s - {{HW{1'b0}}, 1'b1};
  end

  // Stage-2 select: low-slice borrow picks the precomputed high result.
  always_comb begin
    hi_sel_s   = bl_r ? hi1_r : hi0_r;
    bout_sel_s = bl_r ? bh1_r : bh0_r;
  end

  // Stage-1 registers, loaded only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      low_r      <= {SPLIT{1'b0}};
      bl_r       <= 1'b0;
      hi0_r      <= {HW{1'b0}};
      hi1_r      <= {HW{1'b0}};
      bh0_r      <= 1'b0;
      bh1_r      <= 1'b0;
`ifdef SUB_OVF_EN
      sa_r       <= 1'b0;
      sb_r       <= 1'b0;
`endif
    end else begin
      if (accept_s) begin
        s1_valid_r <= 1'b1;
        low_r      <= low_s[SPLIT-1:0];
        bl_r       <= low_s[SPLIT];
        hi0_r      <= hi0_s[HW-1:0];
        hi1_r      <= hi1_s[HW-1:0];
        bh0_r      <= hi0_s[HW];
        bh1_r      <= hi1_s[HW];
`ifdef SUB_OVF_EN
        sa_r       <= A[WIDTH-1];
        sb_r       <= B[WIDTH-1];
`endif
      end else if (s2_adv_s) begin
        s1_valid_r <= 1'b0;
      end else begin
        s1_valid_r <= s1_valid_r;
      end
    end
  end

  // Stage-2 output registers; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      diff_r     <= {WIDTH{1'b0}};
      bout_r     <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_r      <= 1'b0;
`endif
    end else begin
      if (s2_adv_s) begin
        s2_valid_r <= 1'b1;
        diff_r     <= {hi_sel_s, low_r};
        bout_r     <= bout_sel_s;
`ifdef SUB_OVF_EN
        ovf_r      <= (sa_r != sb_r) & (hi_sel_s[HW-1] != sa_r);
`endif
      end else if (out_ready) begin
        s2_valid_r <= 1'b0;
      end else begin
        s2_valid_r <= s2_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_borrow_select_sub_pipe.sv
// Directed and short random checks of borrow_select_sub_pipe against a queue-based arithmetic model.
// Define SUB_OVF_EN to also check the Ovf output.
module tb_borrow_select_sub_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic       Bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Diff;
  logic       Bout;
`ifdef SUB_OVF_EN
  logic       Ovf;
`endif

  borrow_select_sub_pipe #(.WIDTH(8), .SPLIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .Bout      (Bout)
`ifdef SUB_OVF_EN
    ,
    .Ovf       (Ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  int   streak = 0;
  int   max_streak = 0;
  logic       hold_v = 1'b0;
  logic [7:0] hold_d;
  logic       hold_bo;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Expected result from plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t e;
    int   r;
    r    = int'(a) - int'(b) - int'(bin);
    e.d  = r[7:0];
    e.bo = (r < 0);
    e.ov = (a[7] != b[7]) && (e.d[7] != a[7]);
    return e;
  endfunction

  always @(negedge rst_n) exp_q.delete();

  // Scoreboard: push on accept, pop and compare on delivery, check hold under stall.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
      hold_v = 1'b0;
      streak = 0;
    end else begin
      if (out_valid) begin
        streak++;
        if (streak > max_streak) max_streak = streak;
      end else begin
        streak = 0;
      end
      if (hold_v && out_valid) begin
        check("hold_diff", {24'b0, Diff}, {24'b0, hold_d});
        check("hold_bout", {31'b0, Bout}, {31'b0, hold_bo});
      end
      if (out_valid && exp_q.size() == 0) begin
        check("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      end else if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        pops++;
        check("model_diff", {24'b0, Diff}, {24'b0, e.d});
        check("model_bout", {31'b0, Bout}, {31'b0, e.bo});
`ifdef SUB_OVF_EN
        check("model_ovf", {31'b0, Ovf}, {31'b0, e.ov});
`endif
      end
      hold_v  = out_valid && !out_ready;
      hold_d  = Diff;
      hold_bo = Bout;
      if (in_valid && in_ready) exp_q.push_back(model(A, B, Bin));
    end
  end

  // Present one operand set for one cycle; acc reports whether it was taken.
  task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic bin, output logic acc);
    in_valid = 1'b1;
    A = a;
    B = b;
    Bin = bin;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) offer(a, b, bin, acc);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_out(input string name, input logic [7:0] d, input logic bo);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({name, "_diff"}, {24'b0, Diff}, {24'b0, d});
    check({name, "_bout"}, {31'b0, Bout}, {31'b0, bo});
  endtask

  initial begin
    logic acc;
    int   p0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = 8'h00;
    B = 8'h00;
    Bin = 1'b0;
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_diff", {24'b0, Diff}, 32'd0);
    check("rst_bout", {31'b0, Bout}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: not valid one cycle after accept, valid the next.
    send(8'h5A, 8'h23, 1'b0);
    @(negedge clk);
    check("lat_early", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_valid", {31'b0, out_valid}, 32'd1);
    check("lat_diff", {24'b0, Diff}, 32'h37);
    check("lat_bout", {31'b0, Bout}, 32'd0);
    @(posedge clk);
    #1;

    send(8'h10, 8'h01, 1'b1);
    expect_out("split", 8'h0E, 1'b0);
    @(posedge clk);
    #1;
    send(8'h00, 8'h00, 1'b1);
    expect_out("wrap", 8'hFF, 1'b1);
    @(posedge clk);
    #1;

    // Back-to-back random stream.
    p0 = pops;
    max_streak = 0;
    for (int i = 0; i < 16; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
    repeat (4) @(posedge clk);
    #1;
    check("stream_count", pops - p0, 32'd16);
    check("stream_rate", {31'b0, max_streak >= 16}, 32'd1);

    // Backpressure: two accepted, third refused, then drained in order.
    out_ready = 1'b0;
    p0 = pops;
    send(8'h44, 8'h11, 1'b0);
    send(8'h20, 8'h30, 1'b1);
    offer(8'h99, 8'h11, 1'b0, acc);
    check("bp_third_refused", {31'b0, acc}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp_stall_valid", {31'b0, out_valid}, 32'd1);
    check("bp_stall_diff", {24'b0, Diff}, 32'h33);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("bp_delivered", pops - p0, 32'd2);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(8'hF0, 8'h0F, 1'b0);
    send(8'h01, 8'h02, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_diff", {24'b0, Diff}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

`ifdef SUB_OVF_EN
    send(8'h80, 8'h01, 1'b0);
    expect_out("ovf1", 8'h7F, 1'b0);
    check("ovf1_flag", {31'b0, Ovf}, 32'd1);
    @(posedge clk);
    #1;
    send(8'h05, 8'h03, 1'b0);
    expect_out("ovf0", 8'h02, 1'b0);
    check("ovf0_flag", {31'b0, Ovf}, 32'd0);
    @(posedge clk);
    #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
